// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one Wishbone classic master.
// Port A fetches, port B loads/stores; each grant is one line-wide cycle.
module mem_port_arbiter #(
   parameter int CACHE_WIDTH = 128,
   parameter int RETRY_LIMIT = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_a,
   input  logic [31:0]              addr_a,
   output logic [31:0]              dataout_a,
   output logic                     ready_a,
   output logic                     err_a,
   input  logic                     valid_b,
   input  logic [31:0]              addr_b,
   input  logic [31:0]              datain_b,
   input  logic                     wr_b,
   output logic [31:0]              dataout_b,
   output logic                     ready_b,
   output logic                     err_b,
   output logic [31:0]              wb_adr_o,
   output logic [CACHE_WIDTH-1:0]   wb_dat_o,
   input  logic [CACHE_WIDTH-1:0]   wb_dat_i,
   output logic                     wb_we_o,
   output logic [CACHE_WIDTH/8-1:0] wb_sel_o,
   output logic                     wb_stb_o,
   input  logic                     wb_ack_i,
   input  logic                     wb_err_i,
   input  logic                     wb_rty_i,
   output logic                     wb_cyc_o
);

   localparam int SEL_WIDTH = CACHE_WIDTH / 8;
   localparam int OFF_BITS  = $clog2(SEL_WIDTH);
   localparam int LANES     = CACHE_WIDTH / 32;
   localparam logic [3:0] LIMIT = 4'(RETRY_LIMIT);

   typedef enum logic [1:0] {IDLE, BUS, BACKOFF, RESP} state_t;

   state_t        state_q, state_d;
   logic          port_q, port_d;
   logic          last_q, last_d;
   logic          we_q, we_d;
   logic          err_q, err_d;
   logic [3:0]    retry_q, retry_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   douta_q, douta_d;
   logic [31:0]   doutb_q, doutb_d;

   logic                gnt_b;
   logic                bus_act;
   logic [OFF_BITS-1:0] word_off;
   logic [31:0]         rd_word;

   assign word_off = addr_q[OFF_BITS-1:0] >> 2;
   assign rd_word  = wb_dat_i[32*word_off +: 32];
   assign bus_act  = (state_q == BUS);

   // Bus outputs are decoded from the latched request while in BUS.
   always_comb begin
      wb_cyc_o = bus_act;
      wb_stb_o = bus_act;
      wb_we_o  = bus_act & we_q;
      wb_adr_o = '0;
      wb_sel_o = '0;
      wb_dat_o = '0;
      if (bus_act) begin
         wb_adr_o = addr_q & ~32'(SEL_WIDTH - 1);
         wb_sel_o = SEL_WIDTH'(4'hF) << (4 * word_off);
         if (we_q)
            wb_dat_o = {LANES{wdata_q}};
      end
   end

   assign ready_a   = (state_q == RESP) & ~port_q;
   assign ready_b   = (state_q == RESP) &  port_q;
   assign err_a     = ready_a & err_q;
   assign err_b     = ready_b & err_q;
   assign dataout_a = douta_q;
   assign dataout_b = doutb_q;

   // Next-state: arbitration, termination handling, retry accounting.
   always_comb begin
      state_d = state_q;
      port_d  = port_q;
      last_d  = last_q;
      we_d    = we_q;
      err_d   = err_q;
      retry_d = retry_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      douta_d = douta_q;
      doutb_d = doutb_q;
      gnt_b   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (valid_a || valid_b) begin
               gnt_b   = valid_b & (~valid_a | ~last_q);
               port_d  = gnt_b;
               last_d  = gnt_b;
               addr_d  = gnt_b ? addr_b : addr_a;
               wdata_d = gnt_b ? datain_b : 32'd0;
               we_d    = gnt_b & wr_b;
               retry_d = 4'd0;
               err_d   = 1'b0;
               state_d = BUS;
            end
         end
         BUS: begin
            if (wb_ack_i) begin
               if (!we_q) begin
                  if (port_q) doutb_d = rd_word;
                  else        douta_d = rd_word;
               end
               state_d = RESP;
            end else if (wb_err_i) begin
               err_d   = 1'b1;
               state_d = RESP;
            end else if (wb_rty_i) begin
               retry_d = retry_q + 4'd1;
               if (retry_d == LIMIT) begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  state_d = BACKOFF;
               end
            end
         end
         BACKOFF: state_d = BUS;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         port_q  <= 1'b0;
         last_q  <= 1'b0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         retry_q <= 4'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         douta_q <= 32'd0;
         doutb_q <= 32'd0;
      end else begin
         state_q <= state_d;
         port_q  <= port_d;
         last_q  <= last_d;
         we_q    <= we_d;
         err_q   <= err_d;
         retry_q <= retry_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         douta_q <= douta_d;
         doutb_q <= doutb_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a scripted Wishbone slave.
// Bus and response expectations are queued and checked by monitors.
module tb_mem_port_arbiter;

   logic         clk;
   logic         rst;
   logic         valid_a;
   logic [31:0]  addr_a;
   logic [31:0]  dataout_a;
   logic         ready_a;
   logic         err_a;
   logic         valid_b;
   logic [31:0]  addr_b;
   logic [31:0]  datain_b;
   logic         wr_b;
   logic [31:0]  dataout_b;
   logic         ready_b;
   logic         err_b;
   logic [31:0]  wb_adr_o;
   logic [127:0] wb_dat_o;
   logic [127:0] wb_dat_i;
   logic         wb_we_o;
   logic [15:0]  wb_sel_o;
   logic         wb_stb_o;
   logic         wb_ack_i;
   logic         wb_err_i;
   logic         wb_rty_i;
   logic         wb_cyc_o;

   mem_port_arbiter #(.CACHE_WIDTH(128), .RETRY_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .valid_a(valid_a), .addr_a(addr_a), .dataout_a(dataout_a),
      .ready_a(ready_a), .err_a(err_a),
      .valid_b(valid_b), .addr_b(addr_b), .datain_b(datain_b),
      .wr_b(wr_b), .dataout_b(dataout_b),
      .ready_b(ready_b), .err_b(err_b),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
      .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o),
      .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
      .wb_cyc_o(wb_cyc_o)
   );

   typedef struct {
      logic [31:0]  adr;
      logic [15:0]  sel;
      logic         we;
      logic [127:0] dat;
   } bus_t;

   typedef struct {
      logic        port;
      logic        err;
      logic [31:0] data;
   } resp_t;

   bus_t  bus_q[$];
   resp_t resp_q[$];
   int    rises[$];

   int checks = 0;
   int errors = 0;
   int cyc_n  = 0;

   logic stb_prev = 1'b0;
   bus_t  be;
   resp_t re;

   int   rty_n     = 0;
   logic err_mode  = 1'b0;
   logic both_mode = 1'b0;
   logic stall     = 1'b0;
   int   sl_cnt    = 0;

   logic [31:0] model_da;
   logic [31:0] model_db;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic fail(input string tag);
      checks++;
      errors++;
      $error("FAIL %s observed event expected none", tag);
   endtask

   function automatic bus_t mk_bus(input logic [31:0] adr,
                                   input logic [15:0] sel,
                                   input logic we,
                                   input logic [31:0] w);
      bus_t b;
      b.adr = adr;
      b.sel = sel;
      b.we  = we;
      b.dat = we ? {4{w}} : 128'd0;
      return b;
   endfunction

   function automatic resp_t mk_resp(input logic p, input logic e,
                                     input logic [31:0] d);
      resp_t r;
      r.port = p;
      r.err  = e;
      r.data = d;
      return r;
   endfunction

   // Scripted slave: rty_n retries, then err, ack or ack+err.
   always @(negedge clk) begin
      wb_ack_i <= 1'b0;
      wb_err_i <= 1'b0;
      wb_rty_i <= 1'b0;
      if (rst || ready_a || ready_b)
         sl_cnt <= 0;
      else if (wb_stb_o && !stall) begin
         if (sl_cnt < rty_n) begin
            wb_rty_i <= 1'b1;
            sl_cnt   <= sl_cnt + 1;
         end else if (err_mode) begin
            wb_err_i <= 1'b1;
         end else begin
            wb_ack_i <= 1'b1;
            wb_err_i <= both_mode;
         end
      end
   end

   // Monitor: bus cycle starts and port completions against queues.
   always @(negedge clk) begin
      if (!rst) begin
         chk("cyc_eq_stb", wb_cyc_o, wb_stb_o);
         if (wb_stb_o && !stb_prev) begin
            rises.push_back(cyc_n);
            if (bus_q.size() == 0) fail("bus_extra");
            else begin
               be = bus_q.pop_front();
               chk("bus_adr", wb_adr_o, be.adr);
               chk("bus_sel", wb_sel_o, be.sel);
               chk("bus_we",  wb_we_o,  be.we);
               chk("bus_dat", wb_dat_o, be.dat);
            end
         end
         if (ready_a || ready_b) begin
            chk("ready_both", ready_a & ready_b, 1'b0);
            if (resp_q.size() == 0) fail("resp_extra");
            else begin
               re = resp_q.pop_front();
               chk("resp_port", ready_b, re.port);
               chk("resp_err", ready_b ? err_b : err_a, re.err);
               chk("resp_data", ready_b ? dataout_b : dataout_a, re.data);
            end
         end
      end
      stb_prev <= wb_stb_o;
   end

   task automatic wait_ready(input logic port, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(port ? ready_b : ready_a) && n < 100);
      if (!(port ? ready_b : ready_a)) fail("ready_timeout");
   endtask

   task automatic wait_any(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(ready_a || ready_b) && n < 100);
      if (!(ready_a || ready_b)) fail("any_timeout");
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      model_da = 32'd0;
      model_db = 32'd0;
   endtask

   initial begin
      int n;
      int n0;
      rst      = 1'b1;
      valid_a  = 1'b0;
      addr_a   = 32'd0;
      valid_b  = 1'b0;
      addr_b   = 32'd0;
      datain_b = 32'd0;
      wr_b     = 1'b0;
      wb_dat_i = {32'h44444444, 32'hDEADBEEF, 32'h22222222, 32'h11111111};
      model_da = 32'd0;
      model_db = 32'd0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_cyc", wb_cyc_o, 1'b0);
      chk("rst_stb", wb_stb_o, 1'b0);
      chk("rst_bus", {wb_adr_o, wb_sel_o, wb_we_o, wb_dat_o}, 128'd0);
      chk("rst_rdy", {ready_a, ready_b, err_a, err_b}, 4'd0);
      chk("rst_dout", {dataout_a, dataout_b}, 64'd0);
      rst = 1'b0;

      // Single read on A, ack in first strobe cycle
      @(posedge clk);
      #1;
      bus_q.push_back(mk_bus(32'h1000, 16'h0F00, 1'b0, 32'd0));
      model_da = 32'hDEADBEEF;
      resp_q.push_back(mk_resp(1'b0, 1'b0, model_da));
      valid_a = 1'b1;
      addr_a  = 32'h0000_1008;
      wait_ready(1'b0, n);
      valid_a = 1'b0;
      chk("lat_a", n, 3);

      // B read from top word, then B write
      @(posedge clk);
      #1;
      bus_q.push_back(mk_bus(32'h2000, 16'hF000, 1'b0, 32'd0));
      model_db = 32'h44444444;
      resp_q.push_back(mk_resp(1'b1, 1'b0, model_db));
      valid_b = 1'b1;
      addr_b  = 32'h200C;
      wait_ready(1'b1, n);
      valid_b = 1'b0;

      @(posedge clk);
      #1;
      bus_q.push_back(mk_bus(32'h2000, 16'h00F0, 1'b1, 32'h12345678));
      resp_q.push_back(mk_resp(1'b1, 1'b0, model_db));
      valid_b  = 1'b1;
      wr_b     = 1'b1;
      addr_b   = 32'h2004;
      datain_b = 32'h12345678;
      wait_ready(1'b1, n);
      valid_b = 1'b0;
      wr_b    = 1'b0;

      // Ties from reset alternate B, A, B, A
      do_reset();
      n0 = rises.size();
      bus_q.push_back(mk_bus(32'h4000, 16'h00F0, 1'b0, 32'd0));
      bus_q.push_back(mk_bus(32'h3000, 16'h000F, 1'b0, 32'd0));
      bus_q.push_back(mk_bus(32'h4000, 16'h00F0, 1'b0, 32'd0));
      bus_q.push_back(mk_bus(32'h3000, 16'h000F, 1'b0, 32'd0));
      model_da = 32'h11111111;
      model_db = 32'h22222222;
      for (int k = 0; k < 2; k++) begin
         resp_q.push_back(mk_resp(1'b1, 1'b0, model_db));
         resp_q.push_back(mk_resp(1'b0, 1'b0, model_da));
      end
      valid_a = 1'b1;
      addr_a  = 32'h3000;
      valid_b = 1'b1;
      addr_b  = 32'h4004;
      for (int k = 0; k < 4; k++) wait_any(n);
      valid_a = 1'b0;
      valid_b = 1'b0;
      if (rises.size() < n0 + 4) fail("tie_rises");
      else
         for (int i = 0; i < 3; i++)
            chk("tie_gap", rises[n0+i+1] - rises[n0+i], 3);

      // Two retries then ack
      @(posedge clk);
      #1;
      rty_n = 2;
      n0 = rises.size();
      for (int k = 0; k < 3; k++)
         bus_q.push_back(mk_bus(32'h1000, 16'h00F0, 1'b0, 32'd0));
      model_da = 32'h22222222;
      resp_q.push_back(mk_resp(1'b0, 1'b0, model_da));
      valid_a = 1'b1;
      addr_a  = 32'h1004;
      wait_ready(1'b0, n);
      valid_a = 1'b0;
      if (rises.size() < n0 + 3) fail("rty_rises");
      else
         for (int i = 0; i < 2; i++)
            chk("rty_gap", rises[n0+i+1] - rises[n0+i], 2);

      // Slave retries forever: four strobes then error
      @(posedge clk);
      #1;
      rty_n = 15;
      for (int k = 0; k < 4; k++)
         bus_q.push_back(mk_bus(32'h1000, 16'hF000, 1'b0, 32'd0));
      resp_q.push_back(mk_resp(1'b0, 1'b1, model_da));
      valid_a = 1'b1;
      addr_a  = 32'h100C;
      wait_ready(1'b0, n);
      valid_a = 1'b0;
      rty_n = 0;

      // ack and err together count as ack
      @(posedge clk);
      #1;
      both_mode = 1'b1;
      bus_q.push_back(mk_bus(32'h1000, 16'h0F00, 1'b0, 32'd0));
      model_da = 32'hDEADBEEF;
      resp_q.push_back(mk_resp(1'b0, 1'b0, model_da));
      valid_a = 1'b1;
      addr_a  = 32'h1008;
      wait_ready(1'b0, n);
      valid_a = 1'b0;
      both_mode = 1'b0;

      // err termination on B keeps old read data
      @(posedge clk);
      #1;
      err_mode = 1'b1;
      bus_q.push_back(mk_bus(32'h2000, 16'h0F00, 1'b0, 32'd0));
      resp_q.push_back(mk_resp(1'b1, 1'b1, model_db));
      valid_b = 1'b1;
      addr_b  = 32'h2008;
      wait_ready(1'b1, n);
      valid_b = 1'b0;
      err_mode = 1'b0;

      // Reset while the slave stalls a cycle
      @(posedge clk);
      #1;
      stall = 1'b1;
      bus_q.push_back(mk_bus(32'h1000, 16'h000F, 1'b0, 32'd0));
      valid_a = 1'b1;
      addr_a  = 32'h1000;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!wb_stb_o && n < 50);
      if (!wb_stb_o) fail("stall_timeout");
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid_cyc", wb_cyc_o, 1'b0);
      chk("rst_mid_stb", wb_stb_o, 1'b0);
      chk("rst_mid_rdy", {ready_a, ready_b}, 2'b00);
      rst   = 1'b0;
      stall = 1'b0;
      model_da = 32'd0;
      model_db = 32'h22222222;
      bus_q.push_back(mk_bus(32'h4000, 16'h00F0, 1'b0, 32'd0));
      resp_q.push_back(mk_resp(1'b1, 1'b0, model_db));
      valid_b = 1'b1;
      addr_b  = 32'h4004;
      wait_ready(1'b1, n);
      valid_a = 1'b0;
      valid_b = 1'b0;
      chk("rst_dout_a", dataout_a, model_da);

      repeat (5) @(posedge clk);
      #1;
      chk("bus_q_empty", bus_q.size(), 0);
      chk("resp_q_empty", resp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single Wishbone classic master between two 32-bit requesters: port A (instruction fetch, read-only) and port B (data load/store).
- Each granted request becomes one cache-line-wide bus cycle.
- The arbiter steers the addressed 32-bit word between the line-wide bus and the word-wide port, and handles retry and error termination.
- It sits between the pipeline's fetch/memory stages and the CPU's external bus pins.

Parameters:
- CACHE_WIDTH, 128, bus data width in bits. Must be a power of two and at least 32. SEL_WIDTH = CACHE_WIDTH/8 is derived, not overridable.
- RETRY_LIMIT, 4, number of rty terminations tolerated per request before it is failed as an error (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_a  in  1  port A request
- addr_a  in  32  port A byte address; word-aligned, bits [1:0] ignored
- dataout_a  out  32  port A read word
- ready_a  out  1  port A completion pulse
- err_a  out  1  port A error, valid with ready_a
- valid_b  in  1  port B request
- addr_b  in  32  port B byte address; bits [1:0] ignored
- datain_b  in  32  port B write word
- wr_b  in  1  port B write enable
- dataout_b  out  32  port B read word
- ready_b  out  1  port B completion pulse
- err_b  out  1  port B error, valid with ready_b
- wb_adr_o  out  32  line-aligned bus address
- wb_dat_o  out  CACHE_WIDTH  write data
- wb_dat_i  in  CACHE_WIDTH  read data
- wb_we_o  out  1  write enable
- wb_sel_o  out  SEL_WIDTH  byte lane select
- wb_stb_o  out  1  strobe
- wb_ack_i  in  1  normal termination
- wb_err_i  in  1  error termination
- wb_rty_i  in  1  retry termination
- wb_cyc_o  out  1  cycle valid

Behaviour:
- **Reset.** On reset, all outputs are 0, the FSM is in IDLE, last_grant = A, and retry_cnt = 0.
- **Reset mid-operation.** Reset takes effect at the next edge regardless of state. cyc/stb drop and any pending response is discarded; no ready is issued.

FSM states: IDLE, BUS, BACKOFF, RESP.

- **IDLE:** request arbitration.
  - Requests are sampled only in IDLE.
  - One valid: grant that port.
  - Both valid: grant the port that is not last_grant, so the first tie after reset goes to B.
  - On grant, latch the port id, word address, write data and we (wr_b for B; 0 for A). Update last_grant, clear retry_cnt and go to BUS.
- **BUS:** the bus cycle.
  - cyc_o = stb_o = 1.
  - adr_o = latched addr with the low log2(SEL_WIDTH) bits cleared.
  - Word index w = addr[log2(SEL_WIDTH)-1:2].
  - sel_o has only bits [4w+3:4w] set, for reads and writes alike.
  - dat_o is the write word replicated across every 32-bit lane on writes, and 0 on reads.
  - All bus outputs are held stable until termination.
- **Termination priority:** ack > err > rty when several are asserted together.
  - ack: capture the read word wb_dat_i[32w+31:32w] into the granted port's dataout (writes leave dataout unchanged), then go to RESP.
  - err: go to RESP with the error flag set.
  - rty: increment retry_cnt. If retry_cnt is now RETRY_LIMIT, go to RESP with the error flag set; otherwise go to BACKOFF.
- **BACKOFF:** one cycle with cyc = stb = 0, then back to BUS with identical address, data and sel.
- **RESP:** completion.
  - cyc = stb = 0.
  - The granted port's ready is high for exactly this one cycle; its err mirrors the error flag.
  - The other port's ready and err stay 0.
  - Then go to IDLE.
- **Data hold:** dataout_x holds its value until that port's next successful read.
- **Latency:** request in cycle 0, stb in cycle 1. With ack in cycle 1, ready is seen in cycle 2 and the next grant occurs in cycle 3. Throughput is at most 1 request per 3 cycles.
- **Requester rules:**
  - A requester holds valid and its inputs stable until ready.
  - valid still high in the cycle after ready is treated as a new request.
  - Deasserting valid before grant is permitted and is not an error.
- **Bus discipline:**
  - At most one bus cycle is outstanding.
  - cyc_o and stb_o are identical; no pipelined or burst Wishbone.

Test Plan:
- **Single read, port A:** valid_a=1, addr_a=0x0000_1008; slave acks in the first stb cycle with wb_dat_i word2=0xDEADBEEF.
  - Bus shows adr 0x0000_1000, sel 0x0F00, we 0.
  - Two cycles after valid, ready_a=1, err_a=0, dataout_a=0xDEADBEEF.
  - ready_b stays 0.
- **Write, port B:** valid_b=1, wr_b=1, addr_b=0x2004, datain_b=0x12345678.
  - Bus shows adr 0x2000, sel 0x00F0, we 1, dat_o = 0x12345678 in all four lanes.
  - ready_b pulses once; dataout_b is unchanged.
- **Simultaneous requests from reset:** valid_a and valid_b held high throughout.
  - Grant order on the bus is B, A, B, A.
  - Each ready pulses once per grant, and there are 3 cycles between successive stb rising edges.
- **Retry then ack:** slave asserts rty twice, then ack.
  - stb follows high, low, high, low, high; address is identical each time.
  - Single ready; err = 0.
- **Retry exhaustion:** RETRY_LIMIT=4 and the slave always asserts rty.
  - Exactly 4 stb assertions, then ready_a=1 and err_a=1.
  - Simultaneous err+ack from the slave yields a normal ack.
- **Reset mid-transaction:** assert rst while in BUS with the slave stalled.
  - Next cycle cyc = stb = 0 and all readies are 0.
  - After rst releases, a tie is granted to B.
